ov7670_pixel_capture: RTL and testbench

//  Downstream of the SCCB camera configuration stage. Once configuration reports done, this block captures the
//  OV7670 parallel video stream and writes whole frames into the frame buffer feeding digit recognition.
//  It pairs byte-wide RGB565 beats into 16-bit pixels and generates linear write addresses.
//  It also emits per-frame status and error reporting.

---
 rtl/ov7670_pkg.sv | 28 ++
 rtl/ov7670_line_assembler.sv | 102 ++++++++++
 rtl/ov7670_pixel_capture.sv | 130 +++++++++++++
 tb/tb_ov7670_pixel_capture.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// ov7670_pkg
//   Shared definitions for the OV7670 pixel capture path:
//   - state_t       : capture FSM states
//   - H/V defaults  : active window of a VGA frame
//   - rgb565_t      : pixel layout, field widths given by R_BITS/G_BITS/B_BITS
package ov7670_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // RGB565 field widths; red occupies the top bits of the first byte.
  localparam int R_BITS = 5;
  localparam int G_BITS = 6;
  localparam int B_BITS = 5;

  typedef struct packed {
    logic [R_BITS-1:0] r;
    logic [G_BITS-1:0] g;
    logic [B_BITS-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/ov7670_line_assembler.sv
// ov7670_line_assembler
//   Pairs camera bytes into RGB565 pixels and tracks column/line position
//   inside the active window. All inputs are the already-registered camera
//   signals. Counters are held clear while run=0.
// Ports:
//   clk, reset   clock / synchronous active-high reset
//   run          high while a frame is being captured
//   href, d      registered camera HREF and data byte
//   pixel_write  a complete pixel lands inside the active window this cycle
//   pixel        the pixel {first byte, second byte}
//   col, line    current column / line (position of pixel_write)
//   line_after   line count once a line closing this cycle is accounted for
//   line_err     the line closing this cycle was malformed or beyond V_ACTIVE
module ov7670_line_assembler
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int COL_W    = $clog2(H_ACTIVE + 1),
  parameter int LINE_W   = $clog2(V_ACTIVE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              pixel_write,
  output rgb565_t           pixel,
  output logic [COL_W-1:0]  col,
  output logic [LINE_W-1:0] line,
  output logic [LINE_W-1:0] line_after,
  output logic              line_err
);

  localparam logic [COL_W-1:0]  H_MAX = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] V_MAX = LINE_W'(V_ACTIVE);

  logic              href_prev_reg;
  logic              phase_reg;
  logic              col_ovf_reg;   // more than H_ACTIVE pixels seen on this line
  logic [7:0]        hi_byte_reg;
  logic [COL_W-1:0]  col_reg;
  logic [LINE_W-1:0] line_reg;

  logic href_rise;
  logic line_close;
  logic pixel_valid;

  assign href_rise   = run && href && !href_prev_reg;
  assign line_close  = run && !href && href_prev_reg;
  assign pixel_valid = run && href && phase_reg;

  assign pixel       = {hi_byte_reg, d};
  assign pixel_write = pixel_valid && (col_reg < H_MAX) && (line_reg < V_MAX);
  assign col         = col_reg;
  assign line        = line_reg;

  // Lets the frame-end check see a line that closes in the same cycle.
  assign line_after  = (line_close && (line_reg < V_MAX)) ? line_reg + 1'b1 : line_reg;

  // A saturated column counter alone cannot tell H_ACTIVE from more, hence
  // the overflow flag; phase=1 at the close means a dangling odd byte.
  assign line_err    = line_close &&
                       ((col_reg != H_MAX) || col_ovf_reg || phase_reg || (line_reg == V_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      href_prev_reg <= 1'b0;
      phase_reg     <= 1'b0;
      col_ovf_reg   <= 1'b0;
      hi_byte_reg   <= 8'h00;
      col_reg       <= '0;
      line_reg      <= '0;
    end else begin
      href_prev_reg <= href;
      if (!run) begin
        phase_reg   <= 1'b0;
        col_ovf_reg <= 1'b0;
        col_reg     <= '0;
        line_reg    <= '0;
      end else begin
        if (href) begin
          phase_reg <= ~phase_reg;
          if (!phase_reg) hi_byte_reg <= d;
        end else begin
          phase_reg <= 1'b0;
        end

        if (href_rise) begin
          col_reg     <= '0;
          col_ovf_reg <= 1'b0;
        end else if (pixel_valid) begin
          if (col_reg < H_MAX) col_reg <= col_reg + 1'b1;
          else                 col_ovf_reg <= 1'b1;
        end

        if (line_close && (line_reg < V_MAX)) line_reg <= line_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture
//   Captures whole OV7670 RGB565 frames into a linear frame buffer once the
//   camera configuration stage reports done. Capture only starts on a vsync
//   falling edge so a frame is never entered mid-way.
// Ports:
//   clk, reset          camera PCLK / synchronous active-high reset
//   config_done, enable capture armed while both high; dropping either stops
//                       at the next frame boundary
//   vsync, href, d      raw camera pins (registered once here)
//   wr_en/addr/data     frame-buffer write port, addr = line*H_ACTIVE + column
//   frame_done          one-cycle pulse when a captured frame closes
//   frame_err           sticky malformed-frame flag, cleared only by reset
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              config_done,
  input  logic              enable,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam logic [LINE_W-1:0] V_MAX = LINE_W'(V_ACTIVE);

  state_t state_reg, state_next;

  logic       vsync_q, href_q, vsync_prev;
  logic [7:0] d_q;

  logic              run, armed, frame_end, err_set;
  logic              vsync_rise, vsync_fall;
  logic              pixel_write, line_err;
  rgb565_t           pixel;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line, line_after;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      d_q        <= 8'h00;
      vsync_prev <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      href_q     <= href;
      d_q        <= d;
      vsync_prev <= vsync_q;
    end
  end

  assign vsync_rise = vsync_q && !vsync_prev;
  assign vsync_fall = !vsync_q && vsync_prev;
  assign armed      = config_done && enable;
  assign run        = (state_reg == ST_CAPTURE);

  always_comb begin
    state_next = state_reg;
    frame_end  = 1'b0;
    case (state_reg)
      ST_IDLE:    if (armed) state_next = ST_SYNC;
      ST_SYNC: begin
        if (!armed)          state_next = ST_IDLE;
        else if (vsync_fall) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (vsync_rise) begin
          frame_end  = 1'b1;
          state_next = armed ? ST_SYNC : ST_IDLE;
        end
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  ov7670_line_assembler #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COL_W    (COL_W),
    .LINE_W   (LINE_W)
  ) u_line (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .href        (href_q),
    .d           (d_q),
    .pixel_write (pixel_write),
    .pixel       (pixel),
    .col         (col),
    .line        (line),
    .line_after  (line_after),
    .line_err    (line_err)
  );

  // href_q still high at the frame end means vsync cut a line short.
  assign err_set = line_err || (frame_end && ((line_after != V_MAX) || href_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 16'h0000;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_en      <= pixel_write;
      frame_done <= frame_end;
      if (pixel_write) begin
        wr_addr <= ADDR_W'(line) * ADDR_W'(H_ACTIVE) + ADDR_W'(col);
        wr_data <= pixel;
      end
      if (err_set) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Testbench for ov7670_pixel_capture with a 4x2 active window.
// Byte stream per checked frame: 0x12, 0x34, 0x56, ... (step 0x22, mod 256).
module tb_ov7670_pixel_capture;
  import ov7670_pkg::*;

  logic        clk = 1'b0;
  logic        reset, config_done, enable, vsync, href;
  logic [7:0]  d;
  logic        wr_en, frame_done, frame_err;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] nb;          // next byte to drive
  logic [18:0] wa[$];      // logged write addresses
  logic [15:0] wd[$];      // logged write data
  int fd_cnt = 0;          // frame_done pulses seen

  always #5 clk = ~clk;

  ov7670_pixel_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(19)) dut (
    .clk         (clk),
    .reset       (reset),
    .config_done (config_done),
    .enable      (enable),
    .vsync       (vsync),
    .href        (href),
    .d           (d),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
    if (frame_done) fd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] bt(input int i);
    bt = 8'(32'h12 + 32'h22 * i);
  endfunction

  function automatic logic [31:0] qa(input int k);
    qa = (k < wa.size()) ? 32'(wa[k]) : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] qd(input int k);
    qd = (k < wd.size()) ? 32'(wd[k]) : 32'hxxxxxxxx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks four consecutive logged writes of one line.
  task automatic chk_line(input string tag, input int qi, input int base, input int bi);
    for (int p = 0; p < 4; p++) begin
      chk({tag, "_addr"}, qa(qi + p), 32'(base + p));
      chk({tag, "_data"}, qd(qi + p), {16'h0, bt(bi + 2*p), bt(bi + 2*p + 1)});
    end
  endtask

  task automatic cyc(input logic v, input logic h, input logic [7:0] b);
    vsync = v; href = h; d = b;
    @(posedge clk); #1;
  endtask

  task automatic vpulse();
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int nbytes, input bit tail);
    for (int i = 0; i < nbytes; i++) begin
      cyc(1'b0, 1'b1, nb);
      nb = nb + 8'h22;
    end
    if (tail) repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); fd_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; config_done = 1'b0; enable = 1'b1;
    vsync = 1'b0; href = 1'b0; d = 8'h00; nb = 8'h12;

    // Reset with configuration not done; a full frame on the pins.
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    clear_log();
    vpulse(); send_line(8, 1); send_line(8, 1); vpulse();
    chk("unarmed_writes", 32'(wa.size()), 0);
    chk("unarmed_done", 32'(fd_cnt), 0);
    $display("step unarmed frame: writes=%0d done=%0d", wa.size(), fd_cnt);

    // Arm mid-frame: frame A skipped, frame B captured.
    clear_log();
    vpulse(); send_line(8, 1);
    config_done = 1'b1;
    send_line(8, 1);
    vpulse();
    chk("skip_writes", 32'(wa.size()), 0);
    chk("skip_done", 32'(fd_cnt), 0);
    nb = 8'h12;
    send_line(8, 1); send_line(8, 1); vpulse();
    chk("b_writes", 32'(wa.size()), 8);
    chk("b_first_data", qd(0), 32'h1234);
    chk("b_second_data", qd(1), 32'h5678);
    chk("b_last_addr", qa(7), 7);
    chk_line("b_l0", 0, 0, 0);
    chk_line("b_l1", 4, 4, 8);
    chk("b_done", 32'(fd_cnt), 1);
    chk("b_err", 32'(frame_err), 0);
    $display("step frame B: writes=%0d done=%0d err=%0b", wa.size(), fd_cnt, frame_err);

    // Long line (5 pixels) then odd line (9 bytes).
    clear_log(); nb = 8'h12;
    send_line(10, 1);
    chk("long_err", 32'(frame_err), 1);
    send_line(9, 1); vpulse();
    chk("long_writes", 32'(wa.size()), 8);
    chk_line("long_l0", 0, 0, 0);
    chk_line("odd_l1", 4, 4, 10);
    chk("long_done", 32'(fd_cnt), 1);
    $display("step bad lines: writes=%0d done=%0d err=%0b", wa.size(), fd_cnt, frame_err);

    // Reset clears the sticky error; href fall coinciding with vsync rise.
    do_reset();
    chk("rst2_err", 32'(frame_err), 0);
    chk("rst2_wr_en", 32'(wr_en), 0);
    vpulse();
    clear_log(); nb = 8'h12;
    send_line(8, 1); send_line(8, 0); vpulse();
    chk("coinc_writes", 32'(wa.size()), 8);
    chk_line("coinc_l1", 4, 4, 8);
    chk("coinc_done", 32'(fd_cnt), 1);
    chk("coinc_err", 32'(frame_err), 0);
    $display("step coincident close: writes=%0d done=%0d err=%0b", wa.size(), fd_cnt, frame_err);

    // Short frame: one line only.
    clear_log(); nb = 8'h12;
    send_line(8, 1); vpulse();
    chk("short_writes", 32'(wa.size()), 4);
    chk_line("short_l0", 0, 0, 0);
    chk("short_done", 32'(fd_cnt), 1);
    chk("short_err", 32'(frame_err), 1);
    clear_log(); nb = 8'h12;
    send_line(8, 1); send_line(8, 1); vpulse();
    chk("restart_writes", 32'(wa.size()), 8);
    chk("restart_first_addr", qa(0), 0);
    chk("restart_last_addr", qa(7), 7);
    $display("step short frame: writes=%0d done=%0d err=%0b", wa.size(), fd_cnt, frame_err);

    // Drop enable during frame 1.
    clear_log(); nb = 8'h12;
    send_line(8, 1);
    enable = 1'b0;
    send_line(8, 1); vpulse();
    chk("stop_writes", 32'(wa.size()), 8);
    chk("stop_done", 32'(fd_cnt), 1);
    clear_log();
    send_line(8, 1); send_line(8, 1); vpulse();
    chk("idle_writes", 32'(wa.size()), 0);
    chk("idle_done", 32'(fd_cnt), 0);
    chk("idle_state", 32'(dut.state_reg), 32'(ST_IDLE));
    $display("step enable drop: writes=%0d done=%0d", wa.size(), fd_cnt);

    // Vsync rises mid-line: frame aborted, next frame restarts at 0.
    enable = 1'b1;
    do_reset();
    vpulse();
    clear_log(); nb = 8'h12;
    send_line(8, 1);
    send_line(4, 0);
    cyc(1'b1, 1'b1, nb);
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    chk("abort_writes", 32'(wa.size()), 6);
    chk("abort_addr5", qa(5), 5);
    chk("abort_data5", qd(5), {16'h0, bt(10), bt(11)});
    chk("abort_done", 32'(fd_cnt), 1);
    chk("abort_err", 32'(frame_err), 1);
    clear_log(); nb = 8'h12;
    send_line(8, 1); send_line(8, 1); vpulse();
    chk("after_abort_writes", 32'(wa.size()), 8);
    chk_line("after_abort_l0", 0, 0, 0);
    $display("step abort: writes=%0d done=%0d err=%0b", wa.size(), fd_cnt, frame_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
